// File: rtl/apb_write_arbiter.sv
// apb_write_arbiter: shares one APB write master between two write requesters.
// Each requester sends one address, a fixed-length incrementing burst of data
// beats, and then takes one write response. Ports are granted round-robin when
// they contend. Each beat is an APB SETUP/ACCESS pair, and PREADY adds wait states.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   s_awaddr/valid/ready per-port write address channel (port i at slice i)
//   s_wdata/valid/ready  per-port write data channel
//   s_bvalid/bready      per-port write response channel
//   gnt                  one-hot current owner, 0 when idle
//   PSEL..PREADY         APB master (write only)
module apb_write_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*ADDR_W-1:0] s_awaddr,
  input  logic [1:0]          s_awvalid,
  output logic [1:0]          s_awready,
  input  logic [2*DATA_W-1:0] s_wdata,
  input  logic [1:0]          s_wvalid,
  output logic [1:0]          s_wready,
  output logic [1:0]          s_bvalid,
  input  logic [1:0]          s_bready,
  output logic [1:0]          gnt,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  input  logic                PREADY
);

  localparam int unsigned     CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WDATA  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t             state, state_d;
  logic               owner;
  logic               last_gnt;
  logic               win;
  logic [ADDR_W-1:0]  addr;
  logic [CNT_W-1:0]   beat_cnt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state, arbitration and handshake decode
  always_comb begin
    state_d   = state;
    s_awready = '0;
    s_wready  = '0;
    s_bvalid  = '0;
    // A lone requester wins; on a tie the port not served last wins
    win = (s_awvalid == 2'b11) ? ~last_gnt : s_awvalid[1];
    case (state)
      IDLE: begin
        if (|s_awvalid) begin
          s_awready[win] = 1'b1;
          state_d        = WDATA;
        end
      end
      WDATA: begin
        s_wready[owner] = s_wvalid[owner];
        if (s_wvalid[owner]) state_d = SETUP;
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (PREADY) state_d = (beat_cnt == LAST_BEAT) ? RESP : WDATA;
      end
      RESP: begin
        s_bvalid[owner] = 1'b1;
        if (s_bready[owner]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Owner, burst address/count and registered APB/grant outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      owner    <= 1'b0;
      last_gnt <= 1'b1;
      addr     <= '0;
      beat_cnt <= '0;
      gnt      <= '0;
      PSEL     <= 1'b0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PADDR    <= '0;
      PWDATA   <= '0;
    end else begin
      // APB control follows the next state so PSEL rises on SETUP entry
      PSEL    <= (state_d == SETUP) || (state_d == ACCESS);
      PWRITE  <= (state_d == SETUP) || (state_d == ACCESS);
      PENABLE <= (state_d == ACCESS);
      case (state)
        IDLE: begin
          if (|s_awvalid) begin
            owner    <= win;
            addr     <= win ? s_awaddr[ADDR_W +: ADDR_W] : s_awaddr[0 +: ADDR_W];
            beat_cnt <= '0;
            gnt      <= win ? 2'b10 : 2'b01;
          end
        end
        WDATA: begin
          if (s_wvalid[owner]) begin
            PWDATA <= owner ? s_wdata[DATA_W +: DATA_W] : s_wdata[0 +: DATA_W];
            PADDR  <= addr;
          end
        end
        ACCESS: begin
          if (PREADY) begin
            addr     <= addr + ADDR_W'(4);
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (s_bready[owner]) begin
            last_gnt <= owner;
            gnt      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_write_arbiter.sv
// tb_apb_write_arbiter: random and directed write bursts from both requesters.
// A transaction-level reference model checks arbitration, handshakes and APB beats.
module tb_apb_write_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BL = 4;
  localparam int unsigned NB = 16;
  localparam int          TO = 3000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2*AW-1:0] s_awaddr = '0;
  logic [1:0]      s_awvalid = '0;
  logic [1:0]      s_awready;
  logic [2*DW-1:0] s_wdata = '0;
  logic [1:0]      s_wvalid = '0;
  logic [1:0]      s_wready;
  logic [1:0]      s_bvalid;
  logic [1:0]      s_bready = '0;
  logic [1:0]      gnt;
  logic            PSEL, PENABLE, PWRITE;
  logic [AW-1:0]   PADDR;
  logic [DW-1:0]   PWDATA;
  logic            PREADY;

  apb_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .gnt(gnt),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Burst plan: per-port addresses and beat data, consumed in order
  logic [AW-1:0] plan_addr [2][NB];
  logic [DW-1:0] plan_data [2][NB*BL];

  // Reference model (transaction level)
  int            own    = -1;   // current owner, -1 when bus free
  int            last_w = 1;    // port served last
  int            k      = 0;    // beats completed on APB
  int            ph     = 0;    // 0 waiting data, 1 setup, 2 access
  bit            resp   = 1'b0;
  int            bi [2] = '{0, 0};
  int            cur_bi = 0;
  logic [AW-1:0] base   = '0;

  int pr_mode = 0;
  bit abort   = 1'b0;

  // APB slave readiness: always ready or random wait states
  initial begin
    PREADY = 1'b1;
    forever begin
      @(posedge clk); #1;
      PREADY = (pr_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
    end
  end

  // Compare every cycle against model, then advance model by the coming edge
  always @(negedge clk) begin
    logic [1:0]    ex_aw, ex_w, ex_b, ex_g;
    logic [AW-1:0] ex_addr;
    int            w;
    ex_aw = '0; ex_w = '0; ex_b = '0; ex_g = '0; w = 0;
    if (own >= 0) ex_g[own] = 1'b1;
    if (own < 0 && s_awvalid != 2'b00) begin
      w = (s_awvalid == 2'b11) ? (1 - last_w) : (s_awvalid[1] ? 1 : 0);
      ex_aw[w] = 1'b1;
    end
    if (own >= 0 && !resp && ph == 0) ex_w = s_wvalid & ex_g;
    if (resp) ex_b = ex_g;
    check("awready", 64'(s_awready), 64'(ex_aw));
    check("wready",  64'(s_wready),  64'(ex_w));
    check("bvalid",  64'(s_bvalid),  64'(ex_b));
    check("gnt",     64'(gnt),       64'(ex_g));
    check("psel",    64'(PSEL),      64'(ph != 0));
    check("penable", 64'(PENABLE),   64'(ph == 2));
    check("pwrite",  64'(PWRITE),    64'(ph != 0));
    if (ph != 0 && own >= 0 && k < BL) begin
      ex_addr = base + AW'(4 * k);
      check("paddr",  64'(PADDR),  64'(ex_addr));
      check("pwdata", 64'(PWDATA), 64'(plan_data[own][cur_bi*BL + k]));
    end
    if (rst) begin
      own = -1; last_w = 1; k = 0; ph = 0; resp = 1'b0;
    end else if (own < 0) begin
      if (s_awvalid != 2'b00) begin
        own = w; cur_bi = bi[w]; bi[w]++;
        base = plan_addr[w][cur_bi]; k = 0; ph = 0;
      end
    end else if (resp) begin
      if (s_bready[own]) begin
        last_w = own; own = -1; resp = 1'b0;
      end
    end else if (ph == 0) begin
      if (s_wvalid[own]) ph = 1;
    end else if (ph == 1) begin
      ph = 2;
    end else if (PREADY) begin
      k++; ph = 0;
      if (k == BL) resp = 1'b1;
    end
  end

  task automatic clear_port(input int p);
    s_awvalid[p] = 1'b0;
    s_wvalid[p]  = 1'b0;
    s_bready[p]  = 1'b0;
  endtask

  // One complete burst from port p: address, beats with gap cycles, delayed bready
  task automatic do_burst(input int p, input int bidx, input int gap, input int bdly);
    int t;
    @(posedge clk); #1;
    s_awaddr[p*AW +: AW] = plan_addr[p][bidx];
    s_awvalid[p] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!s_awready[p] && t < TO && !abort);
    if (t >= TO) check("aw_timeout", 64'(s_awready[p]), 64'(1));
    @(posedge clk); #1;
    s_awvalid[p] = 1'b0;
    if (abort || t >= TO) begin clear_port(p); return; end
    for (int b = 0; b < BL; b++) begin
      repeat (gap) begin @(posedge clk); #1; end
      s_wdata[p*DW +: DW] = plan_data[p][bidx*BL + b];
      s_wvalid[p] = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!s_wready[p] && t < TO && !abort);
      if (t >= TO) check("w_timeout", 64'(s_wready[p]), 64'(1));
      @(posedge clk); #1;
      s_wvalid[p] = 1'b0;
      if (abort || t >= TO) begin clear_port(p); return; end
    end
    t = 0;
    do begin @(negedge clk); t++; end while (!s_bvalid[p] && t < TO && !abort);
    if (t >= TO) check("b_timeout", 64'(s_bvalid[p]), 64'(1));
    if (abort || t >= TO) begin @(posedge clk); #1; clear_port(p); return; end
    @(posedge clk); #1;
    repeat (bdly) begin @(posedge clk); #1; end
    s_bready[p] = 1'b1;
    @(posedge clk); #1;
    s_bready[p] = 1'b0;
  endtask

  initial begin
    int t;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < NB; i++) begin
        plan_addr[p][i] = $urandom();
        if (i % 4 == 3) plan_addr[p][i] = 32'hFFFF_FFF0 | AW'($urandom_range(0, 15));
        for (int b = 0; b < BL; b++) plan_data[p][i*BL + b] = $urandom();
      end
    plan_addr[0][0] = 32'hAABB_CCDD;
    for (int b = 0; b < BL; b++) plan_data[0][b] = DW'(32'h1234_5678 * (b + 1));
    plan_addr[1][0] = 32'hEEFF_AABB;
    plan_addr[1][2] = 32'hFFFF_FFF8;
    plan_addr[0][12] = 32'h0000_1000;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_psel",   64'(PSEL),    64'(0));
    check("rst_pen",    64'(PENABLE), 64'(0));
    check("rst_pwrite", 64'(PWRITE),  64'(0));
    check("rst_paddr",  64'(PADDR),   64'(0));
    check("rst_pwdata", 64'(PWDATA),  64'(0));
    check("rst_gnt",    64'(gnt),     64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Contention from reset, then both again
    fork
      do_burst(0, 0, 0, 1);
      do_burst(1, 0, 0, 1);
    join
    fork
      do_burst(0, 1, 0, 0);
      do_burst(1, 1, 0, 0);
    join
    // Address wrap, then back-pressure with wait states
    do_burst(1, 2, 0, 0);
    pr_mode = 1;
    do_burst(0, 2, 2, 5);

    // Random traffic on both ports
    fork
      for (int i = 3; i < 11; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        do_burst(0, i, $urandom_range(0, 2), $urandom_range(0, 5));
      end
      for (int i = 3; i < 11; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        do_burst(1, i, $urandom_range(0, 2), $urandom_range(0, 5));
      end
    join

    // Reset after the first beat of a burst, then a fresh burst
    pr_mode = 0;
    fork
      do_burst(0, 11, 0, 0);
      begin
        t = 0;
        do begin @(negedge clk); t++; end while (!(own == 0 && k >= 1) && t < TO);
        if (t >= TO) check("mid_timeout", 64'(k), 64'(1));
        @(posedge clk); #1;
        rst = 1'b1; abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_psel",   64'(PSEL),     64'(0));
        check("mid_gnt",    64'(gnt),      64'(0));
        check("mid_bvalid", 64'(s_bvalid), 64'(0));
        check("mid_paddr",  64'(PADDR),    64'(0));
      end
    join
    @(posedge clk); #1;
    rst = 1'b0; abort = 1'b0;
    do_burst(0, 12, 0, 0);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
